// File: rtl/priority_encoder_pkg.sv
// Shared widths, reset constants and result type for the 4-to-2 priority encoder.
// Optional build macro used by the top level: PRIORITY_ENCODER_4TO2_INREG_EN.
package priority_encoder_pkg;

  localparam int NUM_REQ = 4;
  localparam int CODE_W  = 2;

  localparam logic [CODE_W-1:0] CODE_RST  = 2'b00;
  localparam logic              VALID_RST = 1'b0;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
  } pe_result_t;

  localparam pe_result_t RESULT_RST = '{code: CODE_RST, valid: VALID_RST};

endpackage

// File: rtl/priority_encoder_4to2_core.sv
// Combinational priority logic: highest-numbered active request wins.
// Bit 3 is highest priority; an empty vector reports code 00 with valid low.
module priority_encoder_4to2_core
  import priority_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output pe_result_t         o_result
);

  // The if-chain tests the highest line first, so lower lines never
  // influence the result once a higher line is active.
  always_comb begin
    o_result = RESULT_RST;
    if (i_req[3]) begin
      o_result.code  = 2'b11;
      o_result.valid = 1'b1;
    end else if (i_req[2]) begin
      o_result.code  = 2'b10;
      o_result.valid = 1'b1;
    end else if (i_req[1]) begin
      o_result.code  = 2'b01;
      o_result.valid = 1'b1;
    end else if (i_req[0]) begin
      o_result.code  = 2'b00;
      o_result.valid = 1'b1;
    end
  end

endmodule

// File: rtl/priority_encoder_4to2.sv
// Registered 4-input priority encoder with code {Y1,Y0} and valid V.
// Define PRIORITY_ENCODER_4TO2_INREG_EN to add an input register (latency 2).
module priority_encoder_4to2
  import priority_encoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic I3,
  input  logic I2,
  input  logic I1,
  input  logic I0,
  output logic Y1,
  output logic Y0,
  output logic V
);

  logic [NUM_REQ-1:0] w_req_in;
  logic [NUM_REQ-1:0] w_req;
  pe_result_t         w_result;
  pe_result_t         r_result;

  assign w_req_in = {I3, I2, I1, I0};

`ifdef PRIORITY_ENCODER_4TO2_INREG_EN
  logic [NUM_REQ-1:0] r_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_req <= '0;
    else     r_req <= w_req_in;
  end

  assign w_req = r_req;
`else
  assign w_req = w_req_in;
`endif

  priority_encoder_4to2_core u_core (
    .i_req    (w_req),
    .o_result (w_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_result <= RESULT_RST;
    else     r_result <= w_result;
  end

  assign {Y1, Y0} = r_result.code;
  assign V        = r_result.valid;

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Scoreboard bench for priority_encoder_4to2: stimulus pushes expected results,
// a monitor pops and compares them when they fall due after the pipeline latency.
module tb_priority_encoder_4to2;

`ifdef PRIORITY_ENCODER_4TO2_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic I3, I2, I1, I0;
  logic Y1, Y0, V;

  always #5 clk = ~clk;

  priority_encoder_4to2 dut (
    .clk (clk),
    .rst (rst),
    .I3  (I3),
    .I2  (I2),
    .I1  (I1),
    .I0  (I0),
    .Y1  (Y1),
    .Y0  (Y0),
    .V   (V)
  );

  typedef struct {
    int         due;
    logic [3:0] vec;
    logic [2:0] exp;  // {V, Y1, Y0}
  } sb_item_t;

  sb_item_t q[$];
  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed {V,Y1,Y0} for inputs 0000..1111
  logic [2:0] sweep_exp [16] = '{
    3'b000, 3'b100, 3'b101, 3'b101,
    3'b110, 3'b110, 3'b110, 3'b110,
    3'b111, 3'b111, 3'b111, 3'b111,
    3'b111, 3'b111, 3'b111, 3'b111
  };

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got V=%0b Y=%02b, expected V=%0b Y=%02b",
               name, act[2], act[1:0], exp[2], exp[1:0]);
    end
  endtask

  task automatic push(input logic [3:0] vec, input logic [2:0] exp);
    sb_item_t e;
    e.due = cyc + LAT;
    e.vec = vec;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] vec, input logic [2:0] exp);
    @(negedge clk);
    {I3, I2, I1, I0} = vec;
    push(vec, exp);
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected results never checked, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    sb_item_t e;
    cyc++;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL late_%04b: result due at cycle %0d not checked until %0d", e.vec, e.due, cyc);
      end else begin
        chk($sformatf("enc_%04b", e.vec), {V, Y1, Y0}, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] v4;
    rst = 1'b1;
    {I3, I2, I1, I0} = 4'b1111;
    #1;
    chk("reset_immediate", {V, Y1, Y0}, 3'b000);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {V, Y1, Y0}, 3'b000);
    end
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      v4 = i[3:0];
      drive(v4, sweep_exp[i]);
    end

    // Masking: I3 held high, lower lines toggled
    for (int i = 0; i < 8; i++) begin
      v4 = {1'b1, i[2:0]};
      drive(v4, 3'b111);
    end
    drain();

    // Mid-operation asynchronous reset
    drive(4'b0110, 3'b110);
    drive(4'b0110, 3'b110);
    drain();
    chk("pre_reset", {V, Y1, Y0}, 3'b110);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", {V, Y1, Y0}, 3'b000);
    #1 rst = 1'b0;
    #0 chk("after_release_before_edge", {V, Y1, Y0}, 3'b000);
    push(4'b0110, 3'b110);
    drain();

    // Glitch between edges: only the value at the sampling edge counts
    @(negedge clk);
    {I3, I2, I1, I0} = 4'b0001;
    push(4'b0001, 3'b100);
    #1 {I3, I2, I1, I0} = 4'b1000;
    #1 {I3, I2, I1, I0} = 4'b0001;
    drain();

    // Valid to invalid
    drive(4'b0100, 3'b110);
    drive(4'b0000, 3'b000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
